rib_arbiter: RTL and testbench

- Single-slave bus arbiter for the RIB memory bus, shared by four requesters:
  - M0: EX store write.
  - M1: ID load-read request (the decode stage's memory read request and address).
  - M2: IF instruction fetch.
  - M3: debug/JTAG master.
- Sequences one transaction at a time through a fixed-priority grant and a two-state FSM, with a timeout watchdog.
- Drives the 3-bit pipeline hold flag so decode/fetch stall while a data or debug access owns the bus.

---
 rtl/rib_arbiter_pkg.sv | 46 ++++
 rtl/rib_arbiter_if.sv | 49 ++++
 rtl/rib_prio_enc.sv | 29 ++
 rtl/rib_arbiter.sv | 126 ++++++++++++
 tb/tb_rib_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rib_arbiter_pkg.sv
// Shared definitions for the RIB memory-bus arbiter: hold codes, master indices, bus widths.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
//
// Contents:
//   HOLD_*       pipeline hold codes driven to the stage registers
//   MST_*        fixed master slot indices (also the priority order, MST_EX highest)
//   RIB_*        default bus widths and master count
//   hold_code()  maps arbiter state/grant/requests onto a hold code
package rib_arbiter_pkg;

    // Pipeline hold codes
    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_PC   = 3'b001;
    localparam logic [2:0] HOLD_IF   = 3'b010;
    localparam logic [2:0] HOLD_ID   = 3'b011;

    // Master slots; lower index wins arbitration
    localparam logic [1:0] MST_EX  = 2'd0;  // EX store write
    localparam logic [1:0] MST_ID  = 2'd1;  // ID load read
    localparam logic [1:0] MST_IF  = 2'd2;  // IF instruction fetch
    localparam logic [1:0] MST_DBG = 2'd3;  // debug / JTAG

    // Default RIB bus geometry
    localparam int RIB_ADDR_W = 32;
    localparam int RIB_DATA_W = 32;
    localparam int RIB_N_MST  = 4;

    // Any data or debug master owning (or about to own) the bus freezes decode;
    // a fetch alone only freezes the fetch stage.
    function automatic logic [2:0] hold_code(input logic       busy,
                                             input logic [1:0] grant,
                                             input logic [3:0] req);
        logic [2:0] code;
        code = HOLD_NONE;
        if (busy) begin
            code = (grant == MST_IF) ? HOLD_IF : HOLD_ID;
        end else if (req[MST_EX] || req[MST_ID] || req[MST_DBG]) begin
            code = HOLD_ID;
        end else if (req[MST_IF]) begin
            code = HOLD_IF;
        end
        return code;
    endfunction

endpackage

// File: rtl/rib_arbiter_if.sv
// Bundle of the four-master request side and the single-slave side of the RIB bus.
// Latency: n/a (wires only).
// Backpressure: masters hold m_req_i until m_ack_o; the slave stalls by withholding s_ack_i.
//
// Modports:
//   master - the arbiter: consumes master requests and slave responses, drives acks,
//            the slave request and the pipeline hold code
//   slave  - the surrounding system: drives master requests and the slave response
interface rib_arbiter_if
    import rib_arbiter_pkg::*;
#(
    parameter int ADDR_W = RIB_ADDR_W,
    parameter int DATA_W = RIB_DATA_W,
    parameter int N_MST  = RIB_N_MST
);

    // Master side, packed per master: Mi at [i*W +: W]
    logic [N_MST-1:0]        m_req_i;
    logic [N_MST-1:0]        m_we_i;
    logic [N_MST*ADDR_W-1:0] m_addr_i;
    logic [N_MST*DATA_W-1:0] m_wdata_i;
    logic [N_MST-1:0]        m_ack_o;
    logic                    m_err_o;
    logic [DATA_W-1:0]       m_rdata_o;

    // Slave side
    logic                    s_req_o;
    logic                    s_we_o;
    logic [ADDR_W-1:0]       s_addr_o;
    logic [DATA_W-1:0]       s_wdata_o;
    logic [DATA_W-1:0]       s_rdata_i;
    logic                    s_ack_i;

    // Pipeline hold code
    logic [2:0]              hold_flag_o;

    modport master (
        input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i, s_ack_i,
        output m_ack_o, m_err_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_wdata_o,
               hold_flag_o
    );

    modport slave (
        output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i, s_ack_i,
        input  m_ack_o, m_err_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_wdata_o,
               hold_flag_o
    );

endinterface

// File: rtl/rib_prio_enc.sv
// 4-input fixed-priority encoder: lowest set bit wins (bit 0 highest priority).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to consume the result.
//
// Ports:
//   req  in  4  request vector
//   idx  out 2  index of the winning bit (0 when vld is low)
//   vld  out 1  at least one request bit is set
module rib_prio_enc (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       vld
);

    always_comb begin
        vld = |req;
        idx = 2'd0;
        if (req[0]) begin
            idx = 2'd0;
        end else if (req[1]) begin
            idx = 2'd1;
        end else if (req[2]) begin
            idx = 2'd2;
        end else if (req[3]) begin
            idx = 2'd3;
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Four-master, single-slave RIB bus arbiter with fixed priority and a timeout watchdog.
// Latency: slave request 1 cycle after the request is sampled; ack 1 cycle after s_ack_i (min 2).
// Backpressure: one transaction in flight; other masters wait with m_req_i held until their ack.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         rib_arbiter_if.master: m_* request/ack side, s_* slave side, hold_flag_o
module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int ADDR_W      = RIB_ADDR_W,
    parameter int DATA_W      = RIB_DATA_W,
    parameter int N_MST       = RIB_N_MST,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rib_arbiter_if.master bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Counter only needs to reach TIMEOUT_CYC-1: at that value the transaction ends.
    localparam int                CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [0:0]        state;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  cnt;

    logic              s_req_q;
    logic              s_we_q;
    logic [ADDR_W-1:0] s_addr_q;
    logic [DATA_W-1:0] s_wdata_q;

    logic [N_MST-1:0]  m_ack_q;
    logic              m_err_q;
    logic [DATA_W-1:0] m_rdata_q;

    logic [1:0]        win_idx;
    logic              win_vld;
    logic [N_MST-1:0]  grant_onehot;
    logic              timeout;

    rib_prio_enc u_prio_enc (
        .req (bus.m_req_i[3:0]),
        .idx (win_idx),
        .vld (win_vld)
    );

    always_comb begin
        grant_onehot        = '0;
        grant_onehot[grant] = 1'b1;
    end

    assign timeout = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant     <= 2'd0;
            cnt       <= '0;
            s_req_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_ack_q   <= '0;
            m_err_q   <= 1'b0;
            m_rdata_q <= '0;
        end else begin
            // Completion outputs are single-cycle pulses.
            m_ack_q   <= '0;
            m_err_q   <= 1'b0;
            m_rdata_q <= '0;

            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        // Capture the winner so the slave sees a stable request even
                        // if the master withdraws mid-transaction.
                        grant     <= win_idx;
                        s_we_q    <= bus.m_we_i[win_idx];
                        s_addr_q  <= bus.m_addr_i[win_idx*ADDR_W +: ADDR_W];
                        s_wdata_q <= bus.m_wdata_i[win_idx*DATA_W +: DATA_W];
                        s_req_q   <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // A slave ack beats a simultaneous timeout.
                    if (bus.s_ack_i) begin
                        m_ack_q   <= grant_onehot;
                        m_rdata_q <= s_we_q ? '0 : bus.s_rdata_i;
                        s_req_q   <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (timeout) begin
                        m_ack_q   <= grant_onehot;
                        m_err_q   <= 1'b1;
                        s_req_q   <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    s_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_req_o     = s_req_q;
    assign bus.s_we_o      = s_we_q;
    assign bus.s_addr_o    = s_addr_q;
    assign bus.s_wdata_o   = s_wdata_q;
    assign bus.m_ack_o     = m_ack_q;
    assign bus.m_err_o     = m_err_q;
    assign bus.m_rdata_o   = m_rdata_q;
    assign bus.hold_flag_o = hold_code(state == ST_BUSY, grant, bus.m_req_i[3:0]);

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed self-checking bench for rib_arbiter.
// Latency: n/a.
// Backpressure: the bench plays both the masters and the slave.
module tb_rib_arbiter;
    import rib_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rib_arbiter_if #(.ADDR_W(32), .DATA_W(32), .N_MST(4)) bus ();

    rib_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .N_MST       (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.m_we_i[idx]               = we;
        bus.m_addr_i[idx*32 +: 32]    = addr;
        bus.m_wdata_i[idx*32 +: 32]   = wdata;
        bus.m_req_i[idx]              = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;

        bus.m_req_i   = '0;
        bus.m_we_i    = '0;
        bus.m_addr_i  = '0;
        bus.m_wdata_i = '0;
        bus.s_ack_i   = 1'b0;
        bus.s_rdata_i = '0;

        // ---- reset state ----
        #3;
        chk("rst_s_req",  64'(bus.s_req_o),     64'd0);
        chk("rst_m_ack",  64'(bus.m_ack_o),     64'd0);
        chk("rst_s_addr", 64'(bus.s_addr_o),    64'd0);
        chk("rst_hold",   64'(bus.hold_flag_o), 64'(HOLD_NONE));
        #4 rst_n = 1'b1;
        tick;

        // ---- single M2 read, slave acks first BUSY cycle ----
        set_req(2, 1'b0, 32'h0000_0100, 32'h0);
        #1;
        chk("m2_hold_req",  64'(bus.hold_flag_o), 64'h2);
        chk("m2_sreq_pre",  64'(bus.s_req_o),     64'd0);
        tick;
        chk("m2_sreq",      64'(bus.s_req_o),     64'd1);
        chk("m2_saddr",     64'(bus.s_addr_o),    64'h100);
        chk("m2_swe",       64'(bus.s_we_o),      64'd0);
        chk("m2_hold_busy", 64'(bus.hold_flag_o), 64'h2);
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'hDEAD_BEEF;
        tick;
        chk("m2_ack",       64'(bus.m_ack_o),     64'h4);
        chk("m2_rdata",     64'(bus.m_rdata_o),   64'hDEAD_BEEF);
        chk("m2_err",       64'(bus.m_err_o),     64'd0);
        chk("m2_sreq_done", 64'(bus.s_req_o),     64'd0);
        chk("m2_hold_ack",  64'(bus.hold_flag_o), 64'h2);
        bus.m_req_i[2] = 1'b0;
        bus.s_ack_i    = 1'b0;
        #1;
        chk("m2_hold_idle", 64'(bus.hold_flag_o), 64'h0);
        tick;
        chk("m2_ack_pulse", 64'(bus.m_ack_o),     64'd0);
        chk("m2_rdata_clr", 64'(bus.m_rdata_o),   64'd0);

        // ---- M0 write and M1 read together: M0 first ----
        set_req(0, 1'b1, 32'h10, 32'h55);
        set_req(1, 1'b0, 32'h20, 32'h0);
        #1;
        chk("pr_hold_req",  64'(bus.hold_flag_o), 64'h3);
        tick;
        chk("pr_m0_swe",    64'(bus.s_we_o),      64'd1);
        chk("pr_m0_saddr",  64'(bus.s_addr_o),    64'h10);
        chk("pr_m0_swdata", 64'(bus.s_wdata_o),   64'h55);
        chk("pr_m0_hold",   64'(bus.hold_flag_o), 64'h3);
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'h1234_5678;
        tick;
        chk("pr_m0_ack",    64'(bus.m_ack_o),     64'h1);
        chk("pr_m0_rdata",  64'(bus.m_rdata_o),   64'd0);
        chk("pr_mid_hold",  64'(bus.hold_flag_o), 64'h3);
        bus.m_req_i[0] = 1'b0;
        bus.s_ack_i    = 1'b0;
        tick;
        chk("pr_m1_sreq",   64'(bus.s_req_o),     64'd1);
        chk("pr_m1_saddr",  64'(bus.s_addr_o),    64'h20);
        chk("pr_m1_swe",    64'(bus.s_we_o),      64'd0);
        chk("pr_m1_hold",   64'(bus.hold_flag_o), 64'h3);
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'hCAFE_0001;
        tick;
        chk("pr_m1_ack",    64'(bus.m_ack_o),     64'h2);
        chk("pr_m1_rdata",  64'(bus.m_rdata_o),   64'hCAFE_0001);
        bus.m_req_i[1] = 1'b0;
        bus.s_ack_i    = 1'b0;
        #1;
        chk("pr_hold_end",  64'(bus.hold_flag_o), 64'h0);
        tick;

        // ---- M3 read, slave never acks: timeout ----
        set_req(3, 1'b0, 32'h300, 32'h0);
        bus.s_rdata_i = 32'hFFFF_FFFF;
        tick;
        chk("to_hold_busy", 64'(bus.hold_flag_o), 64'h3);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (bus.m_ack_o != 4'b0000) begin
                lat = i;
                break;
            end
        end
        chk("to_latency",   64'(lat),             64'd16);
        chk("to_ack",       64'(bus.m_ack_o),     64'h8);
        chk("to_err",       64'(bus.m_err_o),     64'd1);
        chk("to_rdata",     64'(bus.m_rdata_o),   64'd0);
        chk("to_sreq",      64'(bus.s_req_o),     64'd0);
        bus.m_req_i[3] = 1'b0;
        tick;
        chk("to_err_pulse", 64'(bus.m_err_o),     64'd0);
        chk("to_idle_sreq", 64'(bus.s_req_o),     64'd0);
        chk("to_idle_hold", 64'(bus.hold_flag_o), 64'h0);

        // ---- slave ack on the same cycle the counter reaches its last value ----
        set_req(1, 1'b0, 32'h440, 32'h0);
        tick;
        for (int i = 0; i < 15; i++) begin
            tick;
        end
        chk("ae_quiet",     64'(bus.m_ack_o),     64'd0);
        chk("ae_sreq",      64'(bus.s_req_o),     64'd1);
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'h0BAD_F00D;
        tick;
        chk("ae_ack",       64'(bus.m_ack_o),     64'h2);
        chk("ae_err",       64'(bus.m_err_o),     64'd0);
        chk("ae_rdata",     64'(bus.m_rdata_o),   64'h0BAD_F00D);
        bus.m_req_i[1] = 1'b0;
        bus.s_ack_i    = 1'b0;
        tick;

        // ---- async reset while BUSY ----
        set_req(2, 1'b0, 32'h400, 32'h0);
        tick;
        chk("rb_sreq_busy", 64'(bus.s_req_o),     64'd1);
        #3;
        rst_n          = 1'b0;
        bus.m_req_i[2] = 1'b0;
        bus.s_ack_i    = 1'b1;
        bus.s_rdata_i  = 32'h1111_2222;
        #1;
        chk("rb_sreq",      64'(bus.s_req_o),     64'd0);
        chk("rb_saddr",     64'(bus.s_addr_o),    64'd0);
        chk("rb_ack",       64'(bus.m_ack_o),     64'd0);
        chk("rb_hold",      64'(bus.hold_flag_o), 64'h0);
        #1 rst_n = 1'b1;
        tick;
        chk("rb_noack1",    64'(bus.m_ack_o),     64'd0);
        tick;
        chk("rb_noack2",    64'(bus.m_ack_o),     64'd0);
        chk("rb_sreq_idle", 64'(bus.s_req_o),     64'd0);
        bus.s_ack_i = 1'b0;
        set_req(2, 1'b0, 32'h500, 32'h0);
        tick;
        chk("rb_new_sreq",  64'(bus.s_req_o),     64'd1);
        chk("rb_new_saddr", 64'(bus.s_addr_o),    64'h500);
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'h5555_AAAA;
        tick;
        chk("rb_new_ack",   64'(bus.m_ack_o),     64'h4);
        chk("rb_new_rdata", 64'(bus.m_rdata_o),   64'h5555_AAAA);
        bus.m_req_i[2] = 1'b0;
        bus.s_ack_i    = 1'b0;
        tick;

        // ---- M1 withdraws mid-BUSY ----
        set_req(1, 1'b0, 32'h600, 32'h0);
        tick;
        chk("wd_saddr0",    64'(bus.s_addr_o),    64'h600);
        bus.m_req_i[1]          = 1'b0;
        bus.m_addr_i[1*32 +: 32] = 32'h0000_0FFF;
        tick;
        tick;
        tick;
        chk("wd_saddr",     64'(bus.s_addr_o),    64'h600);
        chk("wd_sreq",      64'(bus.s_req_o),     64'd1);
        chk("wd_noack",     64'(bus.m_ack_o),     64'd0);
        chk("wd_hold",      64'(bus.hold_flag_o), 64'h3);
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'h0000_0077;
        tick;
        chk("wd_ack",       64'(bus.m_ack_o),     64'h2);
        chk("wd_rdata",     64'(bus.m_rdata_o),   64'h77);
        bus.s_ack_i = 1'b0;
        tick;
        chk("wd_ack_once",  64'(bus.m_ack_o),     64'd0);
        chk("wd_idle_sreq", 64'(bus.s_req_o),     64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
